// File: rtl/iob_cache_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iob_cache_sweep_ctrl_pkg
//  Purpose  : Shared cache constants: sweep FSM encodings and default line
//             index width.
//  Revision : 1.0 - initial release
// ============================================================================
package iob_cache_sweep_ctrl_pkg;

  // Default cache line index width (128 lines)
  localparam int LINE_W_DEFAULT = 7;

  // Sweep controller state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/iob_counter.sv
`default_nettype none
// ============================================================================
//  Module   : iob_counter
//  Purpose  : Up counter with asynchronous reset, synchronous clear that
//             overrides the clock enable, and count enable qualified by it.
//  Revision : 1.0 - initial release
// ============================================================================
module iob_counter #(
  parameter int DATA_W  = 21,
  parameter int RST_VAL = 0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] data_o
);

  localparam logic [DATA_W-1:0] RST_WORD = DATA_W'(RST_VAL);

  // Count register: sync clear wins over the clock enable so a controller
  // reset always lands the index on RST_VAL.
  always_ff @(posedge clk_i, posedge arst_i) begin
    if (arst_i) begin
      data_o <= RST_WORD;
    end else if (rst_i) begin
      data_o <= RST_WORD;
    end else if (cke_i && en_i) begin
      data_o <= data_o + DATA_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_cache_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : iob_cache_sweep_ctrl
//  Purpose  : Walks every cache line index and clears its valid bit, either
//             after reset or on an invalidate request. Requests arriving
//             while a sweep runs collapse into one follow-up sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module iob_cache_sweep_ctrl
  import iob_cache_sweep_ctrl_pkg::*;
#(
  parameter int LINE_W      = LINE_W_DEFAULT,
  parameter int INIT_ON_RST = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              invalidate_i,
  input  logic              mem_ready_i,
  output logic [LINE_W-1:0] line_addr_o,
  output logic              line_we_o,
  output logic              busy_o,
  output logic              ready_o,
  output logic              done_o
);

  localparam logic [1:0]        RST_STATE = (INIT_ON_RST != 0) ? ST_SWEEP : ST_IDLE;
  localparam logic [LINE_W-1:0] LAST_IDX  = {LINE_W{1'b1}};

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              pending;
  logic              pending_nxt;
  logic              start;
  logic              accept;
  logic              last;
  logic              idx_clr;
  logic [LINE_W-1:0] idx;

  // A write retires only when the memory takes it during an enabled cycle;
  // a stalled or frozen cycle keeps presenting the same line.
  assign accept  = line_we_o & mem_ready_i & cke_i;
  assign last    = (idx == LAST_IDX);
  // Index restarts on reset or whenever a new sweep is launched.
  assign idx_clr = rst_i | (cke_i & start);

  iob_counter #(
    .DATA_W  (LINE_W),
    .RST_VAL (0)
  ) u_line_cnt (
    .clk_i  (clk_i),
    .arst_i (1'b0),
    .cke_i  (cke_i),
    .rst_i  (idx_clr),
    .en_i   (accept),
    .data_o (idx)
  );

  // Next-state and pending-request logic. A request seen in DONE launches the
  // next sweep directly so it can never be dropped on the way to IDLE.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    start       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (invalidate_i) begin
          state_nxt = ST_SWEEP;
          start     = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (invalidate_i) begin
          pending_nxt = 1'b1;
        end
        if (accept && last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (pending || invalidate_i) begin
          state_nxt   = ST_SWEEP;
          pending_nxt = 1'b0;
          start       = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        pending_nxt = 1'b0;
      end
    endcase
  end

  // State and pending flag; reset overrides the clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= RST_STATE;
      pending <= 1'b0;
    end else if (cke_i) begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // Outputs decode from registered state only, so they are glitch-free and
  // independent of same-cycle inputs.
  always_comb begin
    line_addr_o = idx;
    line_we_o   = (state == ST_SWEEP);
    done_o      = (state == ST_DONE);
    busy_o      = (state != ST_IDLE) | pending;
    ready_o     = ~busy_o;
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_cache_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob_cache_sweep_ctrl
//  Purpose  : Directed bench for the cache sweep controller (8 lines) with a
//             write-address scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iob_cache_sweep_ctrl;

  localparam int LW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cke;
  logic          inv;
  logic          mr;
  logic [LW-1:0] addr;
  logic          we;
  logic          busy;
  logic          ready;
  logic          done;
  logic [LW-1:0] addr0;
  logic          we0;
  logic          busy0;
  logic          ready0;
  logic          done0;

  int vectors     = 0;
  int miscompares = 0;
  int writes      = 0;
  int dones       = 0;
  int dones_base;

  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] exp_addr;

  always #5 clk = ~clk;

  iob_cache_sweep_ctrl #(.LINE_W(LW), .INIT_ON_RST(1)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cke_i        (cke),
    .invalidate_i (inv),
    .mem_ready_i  (mr),
    .line_addr_o  (addr),
    .line_we_o    (we),
    .busy_o       (busy),
    .ready_o      (ready),
    .done_o       (done)
  );

  iob_cache_sweep_ctrl #(.LINE_W(LW), .INIT_ON_RST(0)) dut0 (
    .clk_i        (clk),
    .rst_i        (rst),
    .cke_i        (cke),
    .invalidate_i (inv),
    .mem_ready_i  (mr),
    .line_addr_o  (addr0),
    .line_we_o    (we0),
    .busy_o       (busy0),
    .ready_o      (ready0),
    .done_o       (done0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int a, input logic w,
                             input logic d, input logic b);
    chk({tag, "_addr"}, 32'(addr), 32'(a));
    chk({tag, "_we"},   32'(we),   32'(w));
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
  endtask

  task automatic push_sweep();
    for (int i = 0; i < N; i++) exp_q.push_back(LW'(i));
  endtask

  // Scoreboard: every accepted write must match the next expected line.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (cke && we && mr) begin
        writes++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL unexpected_write: observed addr %0d expected no write", addr);
        end else begin
          exp_addr = exp_q.pop_front();
          chk("write_addr", 32'(addr), 32'(exp_addr));
        end
      end
      if (done) dones++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cke = 1'b1; inv = 1'b0; mr = 1'b1;
    repeat (3) step();

    // ---- Reset state and auto sweep after reset ----
    chk("rst_we",    32'(we),    32'd1);
    chk("rst_busy",  32'(busy),  32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst0_we",   32'(we0),   32'd0);
    chk("rst0_busy", 32'(busy0), 32'd0);
    chk("rst0_rdy",  32'(ready0), 32'd1);
    writes = 0; dones = 0;
    push_sweep();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      check_state("t1_sweep", i, 1'b1, 1'b0, 1'b1);
      step();
    end
    check_state("t1_done", 0, 1'b0, 1'b1, 1'b1);
    step();
    check_state("t1_idle", 0, 1'b0, 1'b0, 1'b0);
    chk("t1_ready",  32'(ready), 32'd1);
    chk("t1_writes", 32'(writes), 32'd8);
    chk("t1_dones",  32'(dones),  32'd1);

    // ---- Invalidate from IDLE with a 3-cycle memory stall at line 4 ----
    writes = 0;
    push_sweep();
    inv = 1'b1;
    step();
    inv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_state("t2_sweep", i, 1'b1, 1'b0, 1'b1);
      step();
    end
    mr = 1'b0;
    repeat (3) begin
      check_state("t2_stall", 4, 1'b1, 1'b0, 1'b1);
      step();
    end
    mr = 1'b1;
    for (int i = 4; i < N; i++) begin
      check_state("t2_sweep", i, 1'b1, 1'b0, 1'b1);
      step();
    end
    check_state("t2_done", 0, 1'b0, 1'b1, 1'b1);
    step();
    chk("t2_busy",   32'(busy),   32'd0);
    chk("t2_writes", 32'(writes), 32'd8);

    // ---- Three requests during a sweep collapse into one follow-up ----
    dones_base = dones;
    push_sweep();
    push_sweep();
    inv = 1'b1;
    step();
    inv = 1'b0;
    for (int k = 0; k < 2 * (N + 1); k++) begin
      if (k < N)            check_state("t3_sw1", k, 1'b1, 1'b0, 1'b1);
      else if (k == N)      check_state("t3_dn1", 0, 1'b0, 1'b1, 1'b1);
      else if (k < 2*N + 1) check_state("t3_sw2", k - N - 1, 1'b1, 1'b0, 1'b1);
      else                  check_state("t3_dn2", 0, 1'b0, 1'b1, 1'b1);
      inv = (k == 2 || k == 4 || k == 6);
      step();
    end
    inv = 1'b0;
    check_state("t3_idle", 0, 1'b0, 1'b0, 1'b0);
    chk("t3_dones", 32'(dones - dones_base), 32'd2);
    chk("t3_queue", 32'(exp_q.size()), 32'd0);

    // ---- Clock enable freeze at line 2 (request during freeze ignored) ----
    push_sweep();
    inv = 1'b1;
    step();
    inv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_state("t4_sweep", i, 1'b1, 1'b0, 1'b1);
      step();
    end
    cke = 1'b0;
    inv = 1'b1;
    repeat (2) begin
      check_state("t4_frozen", 2, 1'b1, 1'b0, 1'b1);
      step();
    end
    cke = 1'b1;
    inv = 1'b0;
    for (int i = 2; i < N; i++) begin
      check_state("t4_resume", i, 1'b1, 1'b0, 1'b1);
      step();
    end
    check_state("t4_done", 0, 1'b0, 1'b1, 1'b1);
    step();
    check_state("t4_idle", 0, 1'b0, 1'b0, 1'b0);

    // ---- Reset in the middle of a sweep at line 5 ----
    dones_base = dones;
    for (int i = 0; i < 5; i++) exp_q.push_back(LW'(i));
    inv = 1'b1;
    step();
    inv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_state("t5_sweep", i, 1'b1, 1'b0, 1'b1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_state("t5_after_rst", 0, 1'b1, 1'b0, 1'b1);
    chk("t5_rst0_we",   32'(we0),   32'd0);
    chk("t5_rst0_busy", 32'(busy0), 32'd0);
    chk("t5_no_done",   32'(dones - dones_base), 32'd0);
    push_sweep();
    for (int i = 0; i < N; i++) begin
      check_state("t5_resweep", i, 1'b1, 1'b0, 1'b1);
      step();
    end
    check_state("t5_done", 0, 1'b0, 1'b1, 1'b1);
    step();
    chk("t5_busy",  32'(busy), 32'd0);
    chk("t5_dones", 32'(dones - dones_base), 32'd1);
    chk("t5_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iob_cache_sweep_ctrl.md
IOB_CACHE_SWEEP_CTRL -- requirements
Module: iob_cache_sweep_ctrl

Interface
REQ-001 SHALL have parameter LINE_W, default 7: width of the cache line index; sweeps 2**LINE_W lines.
REQ-002 SHALL have parameter INIT_ON_RST, default 1: 1 starts a full sweep automatically after reset.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cke_i  input  1  clock enable; when 0 all state holds.
REQ-006 SHALL have port invalidate_i  input  1  single-cycle request for a full invalidation sweep.
REQ-007 SHALL have port mem_ready_i  input  1  tag/valid memory accepts the current write.
REQ-008 SHALL have port line_addr_o  output  LINE_W  line index being cleared.
REQ-009 SHALL have port line_we_o  output  1  write strobe, valid bit cleared at line_addr_o.
REQ-010 SHALL have port busy_o  output  1  sweep in progress or pending; the cache front end stalls.
REQ-011 SHALL have port ready_o  output  1  equals ~busy_o; the cache may serve accesses.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse when a sweep completes.

Function
REQ-013 SHALL implement FSM states IDLE, SWEEP and DONE.
REQ-014 IDLE->SWEEP SHALL occur when invalidate_i=1 and cke_i=1; the line index clears to 0 on entry.
REQ-015 In SWEEP, line_we_o SHALL be 1 and line_addr_o SHALL equal the index counter.
REQ-016 A write SHALL count as accepted only when line_we_o=1, mem_ready_i=1 and cke_i=1; the index then increments by 1.
REQ-017 When mem_ready_i=0, index, line_addr_o and line_we_o SHALL hold; no line may be skipped or repeated.
REQ-018 Acceptance at index 2**LINE_W-1 SHALL move SWEEP->DONE; the index wraps to 0 and causes no extra write.
REQ-019 DONE SHALL last exactly one cycle with done_o=1 and line_we_o=0; it then goes to IDLE, or to SWEEP if a request is pending.
REQ-020 invalidate_i seen in SWEEP or DONE SHALL set a single pending flag; repeated requests collapse into one; the flag clears on re-entry to SWEEP.
REQ-021 busy_o SHALL be 1 in SWEEP, in DONE, or when pending=1; it SHALL be 0 only in IDLE with no pending request.
REQ-022 Latency with mem_ready_i held at 1: request to first write is 1 cycle; a sweep takes 2**LINE_W write cycles plus 1 DONE cycle.
REQ-023 invalidate_i in IDLE SHALL start a sweep in the same cycle in which it is accepted; no request may be lost.

Reset
REQ-024 rst_i=1 SHALL override cke_i and all inputs; it clears the index to 0, pending to 0 and done_o to 0.
REQ-025 After reset, state SHALL be SWEEP (line_we_o=1, busy_o=1) if INIT_ON_RST=1, else IDLE (line_we_o=0, busy_o=0).
REQ-026 Reset in the middle of a sweep SHALL abort it with no done_o pulse; with INIT_ON_RST=1 a new sweep starts from index 0.

Structure
REQ-027 FSM state encodings and the default LINE_W SHALL be defined in the shared cache header/package; no other constants go there.
REQ-028 The line index SHALL be one iob_counter instance: DATA_W=LINE_W, rst_i=sweep start or reset, en_i=write accepted.
REQ-029 The counter's arst_i SHALL be tied to 0; all reset goes through the synchronous path.

Verification (LINE_W=3, 8 lines)
REQ-030 Reset release with INIT_ON_RST=1 and mem_ready_i=1 -> line_addr_o 0..7 on 8 consecutive cycles, done_o pulses in cycle 9, busy_o=0 in cycle 10.
REQ-031 In IDLE, invalidate_i for 1 cycle, mem_ready_i=0 for 3 cycles at index 4 -> line_addr_o holds at 4 for 4 cycles, then 5..7 are written, exactly 8 writes total.
REQ-032 invalidate_i pulsed 3 times during a sweep -> exactly one extra sweep follows DONE directly, busy_o stays 1 throughout, two done_o pulses total.
REQ-033 rst_i asserted at index 5 -> no done_o pulse; next cycle line_addr_o=0 and line_we_o=1 (INIT_ON_RST=1), or IDLE with busy_o=0 (INIT_ON_RST=0).
REQ-034 cke_i=0 for 2 cycles at index 2 while mem_ready_i=1 -> index, state and outputs are frozen; the sweep resumes at 2.
